rv_alu: RTL and testbench
=========================

Name: rv_alu

Overview:
- 32-bit integer ALU for the RISC-V datapath execute stage.
- Computes one of up to 16 operations on two 32-bit operands, with ZF/SF/CF/OF status flags.
- Result and flags are registered: one-cycle latency, simple valid pipeline.
- Opcode constants are shared with the decoder.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op valid this cycle
- lhs  in  32  left operand
- rhs  in  32  right operand; shifts use rhs[4:0]
- op  in  4  operation select
- out_valid  out  1  res/flags valid
- res  out  32  registered result
- flags  out  4  registered {ZF,SF,CF,OF}, ZF at bit 3

Behaviour:
- Reset: while rst_n=0, res=0, flags=0, out_valid=0, asynchronously.
- Latency: inputs sampled on the rising edge when in_valid=1. res/flags update on that edge; out_valid=1 for the following cycle.
- When in_valid=0: res/flags hold their previous value and out_valid=0.
- No backpressure. A new op is accepted every cycle.
- Opcodes:
  - 0000 add
  - 0001 sll
  - 0010 slt (signed, result 0 or 1)
  - 0011 sltu
  - 0100 xor
  - 0101 srl
  - 0110 or
  - 0111 and
  - 1000 sub
  - 1001 sra
  - 1010 addu
  - 1011 subu
  - 1100/1101 see Optional Feature
  - 1110/1111 reserved: res=0
- Arithmetic is modulo 2^32. Shifts use rhs[4:0]; rhs[31:5] is ignored. sra replicates lhs[31].
- ZF = (res==0) and SF = res[31], for every op including reserved.
- CF:
  - add/addu: carry-out of bit 31.
  - sub/subu: borrow, i.e. 1 when lhs < rhs unsigned.
  - All other ops: 0.
- OF:
  - add: signed overflow (operands same sign, result sign differs).
  - sub: signed overflow (operands differ in sign, result sign differs from lhs).
  - addu/subu and all other ops: 0.
- slt/sltu compare with a full subtract: slt = (lhs <s rhs), sltu = borrow. CF/OF are 0 for these ops.
- Reset asserted mid-operation discards the in-flight result.

Optional Feature:
- Macro: ALU_ROTATE_EN.
- Defined: 1100 = rol (lhs rotated left by rhs[4:0]), 1101 = ror. CF=OF=0; ZF/SF per rule.
- Undefined: 1100/1101 behave as reserved (res=0, ZF=1, SF=CF=OF=0), and no rotate logic is synthesized.

Decomposition:
- Package alu_pkg holds:
  - the 4-bit opcode localparams (ALU_ADD … ALU_SUBU, ALU_ROL, ALU_ROR);
  - flag bit-index constants (FLAG_ZF=3, FLAG_SF=2, FLAG_CF=1, FLAG_OF=0).
- One combinational sub-module alu_addsub computes:
  - inputs: lhs, rhs, sub select;
  - outputs: sum, carry/borrow, signed overflow, signed-less-than.
  - It is shared by add/sub/addu/subu/slt/sltu.

Test Plan:
- add ffffffff+00000001 -> res 00000000, flags ZF1 SF0 CF1 OF0. Then add 7fffffff+10000003 -> 90000002, ZF0 SF1 CF0 OF1. Check out_valid one cycle after in_valid.
- sll 000f0000,2 -> 003c0000. slt ffff0000,00030001 -> 1. slt 0fffffff,00090003 -> 0. sltu f0000000,00000001 -> 0.
- xor 0,1 -> 1. or 0,1 -> 1. and 0d000001,0f000001 -> 0d000001. All with CF=OF=0.
- sub 80000000-0fffffff -> 70000001, CF0 OF1. sub 1-2 -> ffffffff, SF1 CF1 OF0. subu 7fffffff-70000001 -> 0ffffffe, OF0.
- sra 000000f0,1 -> 00000078. sra ffffffff,3 -> ffffffff. addu ffffffff+1 -> 0, ZF1 CF1 OF0. Shift by rhs=00000021 uses amount 1.
- Reset: assert rst_n=0 between clock edges -> res/flags/out_valid clear immediately. Hold in_valid=0 -> res stable, out_valid=0. Op 1110 -> res 0, ZF1.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode and flag-index constants shared between the ALU and the decoder.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_ADDU = 4'b1010;
    localparam logic [3:0] ALU_SUBU = 4'b1011;
    localparam logic [3:0] ALU_ROL  = 4'b1100;
    localparam logic [3:0] ALU_ROR  = 4'b1101;

    localparam int unsigned FLAG_ZF = 3;
    localparam int unsigned FLAG_SF = 2;
    localparam int unsigned FLAG_CF = 1;
    localparam int unsigned FLAG_OF = 0;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: sum, carry (borrow when subtracting),
// signed overflow and signed less-than.
module alu_addsub #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] lhs,
    input  logic [XLEN-1:0] rhs,
    input  logic            sub,
    output logic [XLEN-1:0] sum,
    output logic            carry,
    output logic            ovf,
    output logic            lt
);

    logic [XLEN-1:0] rhs_x;
    logic            cout;

    always_comb begin
        rhs_x        = sub ? ~rhs : rhs;
        {cout, sum}  = {1'b0, lhs} + {1'b0, rhs_x} + {{XLEN{1'b0}}, sub};
        // Two's-complement subtract: borrow is the inverted carry-out.
        carry        = sub ? ~cout : cout;
        ovf          = (lhs[XLEN-1] == rhs_x[XLEN-1]) && (sum[XLEN-1] != lhs[XLEN-1]);
        lt           = sum[XLEN-1] ^ ovf;
    end

endmodule

// File: rtl/rv_alu.sv
// Registered 32-bit RV execute-stage ALU with {ZF,SF,CF,OF} flags.
// Define ALU_ROTATE_EN to enable rol (1100) / ror (1101).
module rv_alu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [XLEN-1:0] lhs,
    input  logic [XLEN-1:0] rhs,
    input  logic [3:0]      op,
    output logic            out_valid,
    output logic [XLEN-1:0] res,
    output logic [3:0]      flags
);

    logic [XLEN-1:0] as_sum;
    logic            as_carry;
    logic            as_ovf;
    logic            as_lt;
    logic            sub_sel;

    logic [4:0]      shamt;
    logic [XLEN-1:0] calc_res;
    logic            calc_cf;
    logic            calc_of;

    logic [XLEN-1:0] res_d, res_q;
    logic [3:0]      flags_d, flags_q;
    logic            valid_d, valid_q;

`ifdef ALU_ROTATE_EN
    logic [5:0]      rot_inv;
`endif

    alu_addsub #(.XLEN(XLEN)) u_addsub (
        .lhs   (lhs),
        .rhs   (rhs),
        .sub   (sub_sel),
        .sum   (as_sum),
        .carry (as_carry),
        .ovf   (as_ovf),
        .lt    (as_lt)
    );

    always_comb begin
        sub_sel = 1'b0;
        case (op)
            ALU_SUB, ALU_SUBU, ALU_SLT, ALU_SLTU: sub_sel = 1'b1;
            default:                              sub_sel = 1'b0;
        endcase
    end

    always_comb begin
        shamt    = rhs[4:0];
        calc_res = '0;
        calc_cf  = 1'b0;
        calc_of  = 1'b0;
`ifdef ALU_ROTATE_EN
        rot_inv  = 6'(XLEN) - {1'b0, shamt};
`endif
        case (op)
            ALU_ADD, ALU_SUB: begin
                calc_res = as_sum;
                calc_cf  = as_carry;
                calc_of  = as_ovf;
            end
            ALU_ADDU, ALU_SUBU: begin
                calc_res = as_sum;
                calc_cf  = as_carry;
            end
            ALU_SLT:  calc_res = {{(XLEN-1){1'b0}}, as_lt};
            ALU_SLTU: calc_res = {{(XLEN-1){1'b0}}, as_carry};
            ALU_SLL:  calc_res = lhs << shamt;
            ALU_SRL:  calc_res = lhs >> shamt;
            ALU_SRA:  calc_res = $signed(lhs) >>> shamt;
            ALU_XOR:  calc_res = lhs ^ rhs;
            ALU_OR:   calc_res = lhs | rhs;
            ALU_AND:  calc_res = lhs & rhs;
`ifdef ALU_ROTATE_EN
            ALU_ROL:  calc_res = (lhs << shamt) | (lhs >> rot_inv);
            ALU_ROR:  calc_res = (lhs >> shamt) | (lhs << rot_inv);
`endif
            default:  calc_res = '0;
        endcase
    end

    always_comb begin
        valid_d = in_valid;
        res_d   = res_q;
        flags_d = flags_q;
        if (in_valid) begin
            res_d            = calc_res;
            flags_d[FLAG_ZF] = (calc_res == '0);
            flags_d[FLAG_SF] = calc_res[XLEN-1];
            flags_d[FLAG_CF] = calc_cf;
            flags_d[FLAG_OF] = calc_of;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign res       = res_q;
    assign flags     = flags_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_rv_alu.sv
// Self-checking bench for rv_alu: directed vectors plus randomized ops
// compared against an arithmetic reference model.
module tb_rv_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [3:0]  op;
    logic        out_valid;
    logic [31:0] res;
    logic [3:0]  flags;

    int vectors;
    int miscompares;

    logic [31:0] exp_res;
    logic [3:0]  exp_flags;
    logic        exp_valid;

    rv_alu #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .lhs       (lhs),
        .rhs       (rhs),
        .op        (op),
        .out_valid (out_valid),
        .res       (res),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {ZF,SF,CF,OF,res} computed with wide integer arithmetic.
    function automatic logic [35:0] model(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [32:0] w;
        longint      sa, sb, sr;
        logic [31:0] r;
        logic        cf, of;
        int unsigned sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b) & 31;
        r  = 32'd0;
        cf = 1'b0;
        of = 1'b0;
        case (o)
            4'd0, 4'd10: begin
                w  = {1'b0, a} + {1'b0, b};
                r  = w[31:0];
                cf = w[32];
                sr = sa + sb;
                if (o == 4'd0) of = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd8, 4'd11: begin
                r  = a - b;
                cf = (a < b);
                sr = sa - sb;
                if (o == 4'd8) of = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd3: r = (a < b) ? 32'd1 : 32'd0;
            4'd1: r = a << sh;
            4'd5: r = a >> sh;
            4'd9: begin
                r = a >> sh;
                for (int unsigned i = 0; i < sh; i++) r[31-i] = a[31];
            end
            4'd4: r = a ^ b;
            4'd6: r = a | b;
            4'd7: r = a & b;
`ifdef ALU_ROTATE_EN
            4'd12: for (int unsigned i = 0; i < 32; i++) r[(i + sh) % 32] = a[i];
            4'd13: for (int unsigned i = 0; i < 32; i++) r[i] = a[(i + sh) % 32];
`endif
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r[31], cf, of, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, clock it, and compare outputs against the model state.
    task automatic step(input logic v, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b);
        logic [35:0] m;
        in_valid = v;
        op       = o;
        lhs      = a;
        rhs      = b;
        if (v) begin
            m         = model(o, a, b);
            exp_res   = m[31:0];
            exp_flags = m[35:32];
        end
        exp_valid = v;
        @(posedge clk);
        #1;
        check("res",       res,              exp_res);
        check("flags",     {28'd0, flags},   {28'd0, exp_flags});
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    endtask

    task automatic dir(input string tag, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef);
        step(1'b1, o, a, b);
        check({tag, "_res"},   res,            er);
        check({tag, "_flags"}, {28'd0, flags}, {28'd0, ef});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_res     = '0;
        exp_flags   = '0;
        exp_valid   = 1'b0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        op          = '0;
        lhs         = '0;
        rhs         = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_res",   res,                32'd0);
        check("rst_flags", {28'd0, flags},     32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        dir("add_wrap",  4'b0000, 32'hffffffff, 32'h00000001, 32'h00000000, 4'b1010);
        dir("add_ovf",   4'b0000, 32'h7fffffff, 32'h10000003, 32'h90000002, 4'b0101);
        step(1'b0, 4'b0000, 32'h0, 32'h0);
        check("valid_drop", {31'd0, out_valid}, 32'd0);
        dir("sll",       4'b0001, 32'h000f0000, 32'h00000002, 32'h003c0000, 4'b0000);
        dir("slt_neg",   4'b0010, 32'hffff0000, 32'h00030001, 32'h00000001, 4'b0000);
        dir("slt_pos",   4'b0010, 32'h0fffffff, 32'h00090003, 32'h00000000, 4'b1000);
        dir("sltu",      4'b0011, 32'hf0000000, 32'h00000001, 32'h00000000, 4'b1000);
        dir("xor",       4'b0100, 32'h00000000, 32'h00000001, 32'h00000001, 4'b0000);
        dir("or",        4'b0110, 32'h00000000, 32'h00000001, 32'h00000001, 4'b0000);
        dir("and",       4'b0111, 32'h0d000001, 32'h0f000001, 32'h0d000001, 4'b0000);
        dir("sub_ovf",   4'b1000, 32'h80000000, 32'h0fffffff, 32'h70000001, 4'b0001);
        dir("sub_brw",   4'b1000, 32'h00000001, 32'h00000002, 32'hffffffff, 4'b0110);
        dir("subu",      4'b1011, 32'h7fffffff, 32'h70000001, 32'h0ffffffe, 4'b0000);
        dir("sra_pos",   4'b1001, 32'h000000f0, 32'h00000001, 32'h00000078, 4'b0000);
        dir("sra_neg",   4'b1001, 32'hffffffff, 32'h00000003, 32'hffffffff, 4'b0100);
        dir("addu_wrap", 4'b1010, 32'hffffffff, 32'h00000001, 32'h00000000, 4'b1010);
        dir("sll_rhs21", 4'b0001, 32'h00000001, 32'h00000021, 32'h00000002, 4'b0000);
        dir("srl_rhs21", 4'b0101, 32'h80000000, 32'h00000021, 32'h40000000, 4'b0000);
        dir("rsvd_e",    4'b1110, 32'h12345678, 32'h9abcdef0, 32'h00000000, 4'b1000);
        dir("rsvd_f",    4'b1111, 32'hffffffff, 32'hffffffff, 32'h00000000, 4'b1000);
`ifdef ALU_ROTATE_EN
        dir("rol",       4'b1100, 32'h80000001, 32'h00000001, 32'h00000003, 4'b0000);
        dir("ror",       4'b1101, 32'h00000001, 32'h00000001, 32'h80000000, 4'b0100);
`else
        dir("rol_off",   4'b1100, 32'h80000001, 32'h00000001, 32'h00000000, 4'b1000);
        dir("ror_off",   4'b1101, 32'h00000001, 32'h00000001, 32'h00000000, 4'b1000);
`endif

        // Hold: in_valid low keeps res/flags and drops out_valid.
        dir("pre_hold",  4'b0100, 32'hdeadbeef, 32'h0000ffff, 32'hdead4110, 4'b0100);
        repeat (3) begin
            step(1'b0, 4'b0000, $urandom, $urandom);
            check("hold_res", res, 32'hdead4110);
        end

        // Asynchronous reset between edges clears outputs immediately.
        dir("pre_rst",   4'b0110, 32'h00f00000, 32'h0000000f, 32'h00f0000f, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_res",   res,                32'd0);
        check("arst_flags", {28'd0, flags},     32'd0);
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // In-flight op when reset hits is discarded.
        in_valid = 1'b1;
        op       = 4'b0000;
        lhs      = 32'h11111111;
        rhs      = 32'h22222222;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("inflight_res",   res,                32'd0);
        check("inflight_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        exp_res   = '0;
        exp_flags = '0;
        step(1'b0, 4'b0000, 32'h0, 32'h0);

        // Randomized back-to-back traffic with corner-biased operands.
        for (int unsigned n = 0; n < 400; n++) begin
            logic [31:0] a, b;
            logic        v;
            v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: a = 32'h80000000;
                1: a = 32'h7fffffff;
                2: a = 32'hffffffff;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: b = $urandom_range(0, 40);
                1: b = a;
                2: b = 32'h00000001;
                default: b = $urandom;
            endcase
            step(v, 4'($urandom_range(0, 15)), a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (limit 200000)");
        $fatal(1, "timeout");
    end

endmodule
